mmio_io_controller: RTL and testbench

//  Parametrised memory-mapped I/O block between processor data port, RAM and board pins.

---
 rtl/mmio_io_controller.sv | 93 +++++++++
 tb/tb_mmio_io_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O block: debounced edge-capturing button inputs and latched output
// registers sitting beside RAM on the processor data port.
module mmio_io_controller #(
    parameter int          N_IN            = 4,
    parameter int          N_OUT           = 2,
    parameter logic [31:0] IN_BASE         = 32'd1000,
    parameter logic [31:0] OUT_BASE        = 32'd2000,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          CNT_W           = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_IN-1:0]      buttons_in,
    input  logic [31:0]          mem_addr,
    input  logic                 mem_wren,
    input  logic [31:0]          mem_wdata,
    input  logic [31:0]          ram_rdata,
    output logic                 ram_wren,
    output logic [31:0]          cpu_rdata,
    output logic [32*N_OUT-1:0]  out_regs,
    output logic [N_IN-1:0]      btn_level,
    output logic                 irq
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  sync_meta;
    logic [N_IN-1:0]  sync;
    logic [N_IN-1:0]  pending;
    logic [CNT_W-1:0] cnt [N_IN];

    logic [N_IN-1:0]  in_hit;
    logic [N_OUT-1:0] out_hit;
    logic             io_hit;
    logic [N_IN-1:0]  rise;
    logic [N_IN-1:0]  clr;

    // Decode, read steering and per-channel set/clear requests.
    always_comb begin
        // NOTE: every output gets a default first so no path through the loops infers a latch.
        in_hit    = '0;
        out_hit   = '0;
        rise      = '0;
        clr       = '0;
        cpu_rdata = ram_rdata;
        for (int i = 0; i < N_IN; i++) begin
            in_hit[i] = (mem_addr == IN_BASE + 32'(i));
            rise[i]   = sync[i] && !btn_level[i] && (cnt[i] == LAST);
            clr[i]    = mem_wren && in_hit[i] && mem_wdata[1];
            if (in_hit[i]) cpu_rdata = {30'b0, pending[i], btn_level[i]};
        end
        for (int j = 0; j < N_OUT; j++) begin
            out_hit[j] = (mem_addr == OUT_BASE + 32'(j));
            if (out_hit[j]) cpu_rdata = out_regs[32*j +: 32];
        end
        io_hit = |in_hit || |out_hit;
    end

    assign ram_wren = mem_wren && !io_hit;
    assign irq      = |pending;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the output register file is reset too; its value is visible on the pins.
            sync_meta <= '0;
            sync      <= '0;
            btn_level <= '0;
            pending   <= '0;
            out_regs  <= '0;
            for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
        end else begin
            sync_meta <= buttons_in;
            sync      <= sync_meta;
            for (int i = 0; i < N_IN; i++) begin
                if (sync[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    btn_level[i] <= sync[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            // A rising edge landing with a W1C keeps the flag set.
            pending <= (pending & ~clr) | rise;
            for (int j = 0; j < N_OUT; j++) begin
                if (mem_wren && out_hit[j]) out_regs[32*j +: 32] <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Scoreboard bench for mmio_io_controller: stimulus queues expectations, negedge monitor checks.
module tb_mmio_io_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  buttons_in;
    logic [31:0] mem_addr;
    logic        mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
    logic        ram_wren;
    logic [31:0] cpu_rdata;
    logic [63:0] out_regs;
    logic [3:0]  btn_level;
    logic        irq;

    mmio_io_controller #(
        .N_IN(4), .N_OUT(2), .IN_BASE(32'd1000), .OUT_BASE(32'd2000),
        .DEBOUNCE_CYCLES(4), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .buttons_in(buttons_in),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .ram_rdata(ram_rdata), .ram_wren(ram_wren), .cpu_rdata(cpu_rdata),
        .out_regs(out_regs), .btn_level(btn_level), .irq(irq)
    );

    always #5 clock = ~clock;

    typedef enum {S_RDATA, S_RAMWREN, S_IRQ, S_LEVEL, S_OUTREGS} sig_e;
    typedef struct {
        sig_e        sig;
        logic [63:0] val;
        string       name;
    } exp_t;
    typedef struct {
        int ch;
        int cycle;
    } rise_t;

    exp_t  exp_q[$];
    rise_t rise_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    logic [3:0] prev_level = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_sig(input sig_e s, input logic [63:0] v, input string n);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic expect_rise(input int ch, input int at);
        rise_t r;
        r.ch    = ch;
        r.cycle = at;
        rise_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: debounced-level rises are DUT events matched against queued predictions;
    // other expectations are compared against the DUT state at mid-cycle.
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (btn_level[i] === 1'b1 && prev_level[i] === 1'b0 && !reset) begin
                if (rise_q.size() == 0) begin
                    check("unexpected_rise", 64'(i), 64'hFFFF);
                end else begin
                    rise_t r;
                    r = rise_q.pop_front();
                    check("rise_channel", 64'(i), 64'(r.ch));
                    check("rise_cycle", 64'(cyc), 64'(r.cycle));
                end
            end
        end
        prev_level = btn_level;
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e = exp_q.pop_front();
            case (e.sig)
                S_RDATA:   act = 64'(cpu_rdata);
                S_RAMWREN: act = 64'(ram_wren);
                S_IRQ:     act = 64'(irq);
                S_LEVEL:   act = 64'(btn_level);
                default:   act = out_regs;
            endcase
            check(e.name, act, e.val);
        end
    end

    int f_cyc, g_cyc, h_cyc, r_cyc;
    logic [31:0] ram_addrs [4];

    initial begin
        reset      = 1'b1;
        buttons_in = 4'b1111;
        mem_addr   = 32'd5;
        mem_wren   = 1'b0;
        mem_wdata  = 32'd0;
        ram_rdata  = 32'h1234;

        // T1: reset with all buttons high
        tick(); tick();
        expect_sig(S_OUTREGS, 64'd0, "t1_out_regs");
        expect_sig(S_LEVEL, 64'd0, "t1_level");
        expect_sig(S_IRQ, 64'd0, "t1_irq");
        expect_sig(S_RDATA, 64'h1234, "t1_ram_read");
        expect_sig(S_RAMWREN, 64'd0, "t1_ram_wren_idle");
        reset      = 1'b0;
        buttons_in = 4'b0000;
        tick();

        // T2: bouncing button 0, final toggle high
        for (int k = 0; k < 5; k++) begin
            buttons_in[0] = (k % 2 == 0);
            if (k < 4) begin
                tick(); tick();
            end
        end
        f_cyc = cyc;
        expect_rise(0, f_cyc + 6);
        repeat (5) tick();
        expect_sig(S_LEVEL, 64'd0, "t2_level_before");
        expect_sig(S_IRQ, 64'd0, "t2_irq_before");
        tick();
        mem_addr = 32'd1000;
        expect_sig(S_LEVEL, 64'd1, "t2_level_after");
        expect_sig(S_IRQ, 64'd1, "t2_irq");
        expect_sig(S_RDATA, 64'h3, "t2_read_1000");
        tick();

        // T3: W1C on channel 0
        mem_wren = 1'b1; mem_wdata = 32'h1;
        expect_sig(S_RAMWREN, 64'd0, "t3_ram_wren_w1");
        tick();
        mem_wren = 1'b0;
        expect_sig(S_RDATA, 64'h3, "t3_after_w1");
        expect_sig(S_IRQ, 64'd1, "t3_irq_after_w1");
        tick();
        mem_wren = 1'b1; mem_wdata = 32'h2;
        expect_sig(S_RAMWREN, 64'd0, "t3_ram_wren_w2");
        tick();
        mem_wren = 1'b0;
        expect_sig(S_RDATA, 64'h1, "t3_after_clear");
        expect_sig(S_IRQ, 64'd0, "t3_irq_cleared");
        tick();

        // T4: W1C on channel 1 in the same cycle its debounce completes
        buttons_in[1] = 1'b1;
        g_cyc = cyc;
        expect_rise(1, g_cyc + 6);
        mem_addr = 32'd1001;
        repeat (5) tick();
        mem_wren = 1'b1; mem_wdata = 32'h2;
        expect_sig(S_RDATA, 64'h0, "t4_before");
        tick();
        mem_wren = 1'b0;
        expect_sig(S_RDATA, 64'h3, "t4_set_wins");
        expect_sig(S_IRQ, 64'd1, "t4_irq");
        tick();
        mem_wren = 1'b1; mem_wdata = 32'h2;
        tick();
        mem_wren = 1'b0;
        expect_sig(S_RDATA, 64'h1, "t4_cleared");
        expect_sig(S_IRQ, 64'd0, "t4_irq_cleared");
        tick();
        mem_addr = 32'd1000;
        expect_sig(S_RDATA, 64'h1, "t4_ch0_unchanged");
        tick();

        // T5: output registers and RAM pass-through
        mem_addr = 32'd2001; mem_wren = 1'b1; mem_wdata = 32'hDEADBEEF;
        expect_sig(S_RAMWREN, 64'd0, "t5_ram_wren_io");
        tick();
        mem_addr = 32'd2000; mem_wdata = 32'hCAFEF00D;
        expect_sig(S_OUTREGS, 64'hDEADBEEF_00000000, "t5_out_reg1");
        tick();
        mem_wren = 1'b0; mem_addr = 32'd2001;
        expect_sig(S_OUTREGS, 64'hDEADBEEF_CAFEF00D, "t5_out_both");
        expect_sig(S_RDATA, 64'hDEADBEEF, "t5_read_2001");
        tick();
        mem_addr = 32'd2000;
        expect_sig(S_RDATA, 64'hCAFEF00D, "t5_read_2000");
        tick();
        ram_addrs[0] = 32'd12;   ram_addrs[1] = 32'd999;
        ram_addrs[2] = 32'd1004; ram_addrs[3] = 32'd2002;
        for (int k = 0; k < 4; k++) begin
            mem_addr = ram_addrs[k]; mem_wren = 1'b1; mem_wdata = 32'h55;
            expect_sig(S_RAMWREN, 64'd1, "t5_ram_wren_ram");
            expect_sig(S_RDATA, 64'h1234, "t5_ram_read");
            tick();
        end
        mem_wren = 1'b0;
        expect_sig(S_OUTREGS, 64'hDEADBEEF_CAFEF00D, "t5_out_unchanged");
        tick();

        // T6: reset in the middle of button 2 debounce
        mem_addr = 32'd1002;
        buttons_in[2] = 1'b1;
        h_cyc = cyc;
        repeat (4) tick();
        reset = 1'b1;
        buttons_in = 4'b0100;
        tick();
        reset = 1'b0;
        r_cyc = cyc;
        expect_sig(S_LEVEL, 64'd0, "t6_level_reset");
        expect_sig(S_IRQ, 64'd0, "t6_irq_reset");
        expect_sig(S_OUTREGS, 64'd0, "t6_out_reset");
        expect_sig(S_RDATA, 64'h0, "t6_read_reset");
        expect_rise(2, r_cyc + 6);
        repeat (5) tick();
        expect_sig(S_LEVEL, 64'd0, "t6_level_before");
        tick();
        expect_sig(S_LEVEL, 64'h4, "t6_level_after");
        expect_sig(S_IRQ, 64'd1, "t6_irq");
        expect_sig(S_RDATA, 64'h3, "t6_read_1002");
        tick(); tick();

        check("missing_rises", 64'(rise_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
